// File: rtl/multicycle_mem_responder.sv
// Unified fetch/load/store memory responder for the multicycle RV32 core.
// Valid/ready request channel, registered one-cycle response pulse, programmable wait states.
module multicycle_mem_responder #(
    parameter int    ADDR_WIDTH    = 32,
    parameter int    DATA_WIDTH    = 32,
    parameter int    DEPTH_WORDS   = 1024,
    parameter int    READ_LATENCY  = 2,
    parameter int    WRITE_LATENCY = 1,
    parameter string INIT_FILE     = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);
    localparam int IDX_W   = (DEPTH_WORDS < 2) ? 1 : $clog2(DEPTH_WORDS);

    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM   = (ADDR_WIDTH-2)'(DEPTH_WORDS);
    localparam logic [CNT_W-1:0]      RD_CNT_INIT = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]      WR_CNT_INIT = CNT_W'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
    logic [DATA_WIDTH-1:0]   rd_word_q;

    logic                    accept;
    logic                    enter_resp;
    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    acc_err;
    logic [IDX_W-1:0]        acc_idx;
    logic                    lat_is_one;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // A latency-1 request enters RESP on its acceptance edge, so the array
    // port must see the live request in IDLE and the latched one otherwise.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end
        acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[ADDR_WIDTH-1:2] >= DEPTH_LIM);
        acc_idx    = acc_addr[IDX_W+1:2];
        lat_is_one = acc_we ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        enter_resp  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = req_we ? WR_CNT_INIT : RD_CNT_INIT;
                    if (lat_is_one) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                // The pulse is registered, so it appears in the cycle after RESP.
                state_d     = S_IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = acc_err;
                rsp_rdata_d = (we_q || acc_err) ? '0 : rd_word_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage has no reset; a reset on the RESP entry edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (enter_resp && !rst && !acc_err) begin
            if (acc_we) begin
                mem[acc_idx] <= acc_wdata;
            end
            rd_word_q <= mem[acc_idx];
        end
    end

endmodule

// File: tb/tb_multicycle_mem_responder.sv
// Self-checking bench for multicycle_mem_responder: vector table, hand-written
// corner sequences and randomized traffic against an associative-array memory model.
module tb_multicycle_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1, req_valid0, req_valid1, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready0, rsp_valid0, rsp_err0, busy0;
    logic        req_ready1, rsp_valid1, rsp_err1, busy1;
    logic [31:0] rsp_rdata0, rsp_rdata1;

    multicycle_mem_responder u_dut0 (
        .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready0),
        .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .busy(busy0)
    );

    multicycle_mem_responder #(.WRITE_LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready1),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .busy(busy1)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        cur_sel = 1'b0;
    logic        s_ready, s_valid, s_err;
    logic [31:0] s_rdata;
    assign s_ready = cur_sel ? req_ready1 : req_ready0;
    assign s_valid = cur_sel ? rsp_valid1 : rsp_valid0;
    assign s_err   = cur_sel ? rsp_err1   : rsp_err0;
    assign s_rdata = cur_sel ? rsp_rdata1 : rsp_rdata0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vt [14];
    logic [31:0] mem_m [int];
    int          acc_cyc [$];
    logic [31:0] got_data [$];
    logic [31:0] plan_addr [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One complete request on the selected DUT; returns data, error flag and
    // the number of cycles from acceptance edge to the response pulse.
    task automatic run_req(input logic sel, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat);
        logic early;
        early   = 1'b0;
        cur_sel = sel;
        @(negedge clk);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        if (sel) req_valid1 = 1'b1;
        else     req_valid0 = 1'b1;
        #1;
        check("ready_idle", 64'(s_ready), 64'd1);
        @(negedge clk);
        req_valid0 = 1'b0;
        req_valid1 = 1'b0;
        lat = 0;
        while (!s_valid && lat < 20) begin
            if (s_ready) early = 1'b1;
            @(negedge clk);
            lat++;
        end
        rdata = s_rdata;
        err   = s_err;
        check("ready_in_flight", 64'(early), 64'd0);
        check("ready_at_rsp", 64'(s_ready), 64'd1);
        @(negedge clk);
        check("rsp_clear", {30'd0, s_valid, s_err, s_rdata}, 64'd0);
        $display("txn dut=%0d we=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 sel, we, addr, wdata, rdata, err, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lt;
        int          pulses;
        logic [31:0] a;
        logic        w;
        logic        err_m;
        logic [31:0] exp_rd;
        int          r;

        vt[0]  = '{1'b1, 32'h0000_0000, 32'h0A0A_0A0A, 32'h0,         1'b0};
        vt[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vt[2]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vt[3]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         1'b0};
        vt[4]  = '{1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0};
        vt[5]  = '{1'b0, 32'h0000_0022, 32'h0,         32'h0,         1'b1};
        vt[6]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
        vt[7]  = '{1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 32'h0,         1'b1};
        vt[8]  = '{1'b1, 32'h0000_0021, 32'hBAD1_BAD1, 32'h0,         1'b1};
        vt[9]  = '{1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678, 1'b0};
        vt[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0A0A_0A0A, 1'b0};
        vt[11] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0,         1'b0};
        vt[12] = '{1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
        vt[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1};

        // Reset with a pending request: nothing may be accepted.
        rst0 = 1'b1; rst1 = 1'b1;
        req_valid0 = 1'b1; req_valid1 = 1'b0;
        req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(req_ready0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_rsp", {30'd0, rsp_valid0, rsp_err0, rsp_rdata0}, 64'd0);
        check("rst1_ready", 64'(req_ready1), 64'd0);
        rst0 = 1'b0; rst1 = 1'b0; req_valid0 = 1'b0;
        #1;
        check("ready_after_rst", 64'(req_ready0), 64'd1);
        @(negedge clk);
        check("no_accept_in_rst", 64'(busy0), 64'd0);

        // Directed vector table on the default-latency instance.
        for (int i = 0; i < 14; i++) begin
            run_req(1'b0, vt[i].we, vt[i].addr, vt[i].wdata, rd, er, lt);
            check("vec_rdata", 64'(rd), 64'(vt[i].exp_rdata));
            check("vec_err", 64'(er), 64'(vt[i].exp_err));
            check("vec_lat", 64'(lt), vt[i].we ? 64'd1 : 64'd2);
        end

        // Known contents for the low 64 words.
        for (int i = 0; i < 64; i++) begin
            mem_m[i] = $urandom;
            run_req(1'b0, 1'b1, 32'(i * 4), mem_m[i], rd, er, lt);
            check("pre_lat", 64'(lt), 64'd1);
        end

        // Back-to-back reads with req_valid held high; address wobbles mid-flight.
        plan_addr[0] = 32'h40; plan_addr[1] = 32'h44; plan_addr[2] = 32'h48;
        cur_sel = 1'b0;
        @(negedge clk);
        req_we = 1'b0;
        req_valid0 = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (acc_cyc.size() == 3 && c > acc_cyc[2]) req_valid0 = 1'b0;
            if (rsp_valid0) got_data.push_back(rsp_rdata0);
            if (req_valid0 && req_ready0 && acc_cyc.size() < 3) begin
                acc_cyc.push_back(c);
                req_addr = plan_addr[acc_cyc.size() - 1];
            end else begin
                req_addr  = 32'h100 + 32'($urandom_range(0, 15) << 2);
                req_wdata = $urandom;
            end
        end
        req_valid0 = 1'b0;
        check("b2b_accepts", 64'(acc_cyc.size()), 64'd3);
        check("b2b_pulses", 64'(got_data.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < acc_cyc.size()) check("b2b_acc_cycle", 64'(acc_cyc[k]), 64'(3 * k));
            if (k < got_data.size()) check("b2b_rdata", 64'(got_data[k]), 64'(mem_m[16 + k]));
        end
        $display("txn b2b accepts=%0d pulses=%0d", acc_cyc.size(), got_data.size());

        // Write latency 3 abandoned by reset in its first WAIT cycle.
        run_req(1'b1, 1'b1, 32'h30, 32'h01D0_0030, rd, er, lt);
        check("wl3_lat", 64'(lt), 64'd3);
        cur_sel = 1'b1;
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hEEEE_0030; req_valid1 = 1'b1;
        @(negedge clk);
        req_valid1 = 1'b0;
        check("wl3_busy", 64'(busy1), 64'd1);
        rst1 = 1'b1;
        @(negedge clk);
        check("abort_rsp", 64'(rsp_valid1), 64'd0);
        check("abort_busy", 64'(busy1), 64'd0);
        check("abort_ready_in_rst", 64'(req_ready1), 64'd0);
        rst1 = 1'b0;
        #1;
        check("abort_ready_after", 64'(req_ready1), 64'd1);
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid1) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);
        $display("txn dut=1 reset-abort write addr=00000030 pulses=%0d", pulses);
        run_req(1'b1, 1'b0, 32'h30, 32'h0, rd, er, lt);
        check("abort_old_data", 64'(rd), 64'h01D0_0030);
        check("abort_read_lat", 64'(lt), 64'd2);

        // Randomized traffic against the memory model.
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 19));
            if (r < 14)      a = 32'($urandom_range(0, 63) << 2);
            else if (r < 17) a = 32'($urandom_range(0, 63) << 2) | 32'($urandom_range(1, 3));
            else if (r < 19) a = 32'h1000 + 32'($urandom_range(0, 1023) << 2);
            else             a = $urandom | 32'h8000_0000;
            w = 1'($urandom_range(0, 1));
            err_m  = (a % 4 != 0) || (a / 4 >= 1024);
            exp_rd = (err_m || w) ? 32'h0 : mem_m[int'(a / 4)];
            r = int'($urandom);
            run_req(1'b0, w, a, 32'(r), rd, er, lt);
            if (w && !err_m) mem_m[int'(a / 4)] = 32'(r);
            check("rnd_rdata", 64'(rd), 64'(exp_rd));
            check("rnd_err", 64'(er), 64'(err_m));
            check("rnd_lat", 64'(lt), w ? 64'd1 : 64'd2);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
